// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } pipe_state_t;

  // Register zero is hardwired, so a load targeting it never creates a dependency.
  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/hazard_detect_unit.sv
// Combinational load-use detector: flags an ID instruction that reads the
// destination of a load currently in EX.
module hazard_detect_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rt,
  output logic              lu_hazard
);

  always_comb begin
    lu_hazard = ex_memread
             && (ex_rt != REG_AW'(REG_ZERO))
             && ((ex_rt == id_rs) || (ex_rt == id_rt));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe with data-memory watchdog.
// Optional perf counters (stall_cycles, flush_events) under PIPE_PERF_CNT_EN.
//
//  state    | meaning
//  RUN      | normal flow; branch flush / load-use bubble decoded here
//  MEM_WAIT | pipe frozen waiting for data memory, wait_cnt counting
//  ERR      | memory timeout, pipe frozen until reset
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int REG_AW       = 5
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int CNT_W        = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              memwb_bubble,
  output logic              mem_timeout
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
`endif
);

  localparam int WCW = $clog2(MEM_WAIT_MAX + 1);

  pipe_state_t    state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           lu_hazard;
  logic           frozen;
  logic           pc_c, ifid_c, idex_c, exmem_c, ifid_fl_c, idex_fl_c, bubble_c;

  hazard_detect_unit #(.REG_AW(REG_AW)) u_hdu (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .lu_hazard  (lu_hazard)
  );

  // The exit cycle of MEM_WAIT (mem_ready high) decodes exactly like RUN.
  always_comb begin
    frozen = 1'b0;
    case (state_q)
      RUN:      frozen = mem_req && !mem_ready;
      MEM_WAIT: frozen = !mem_ready;
      default:  frozen = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WCW'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WCW'(MEM_WAIT_MAX)) begin
          state_d = ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    pc_c      = 1'b1;
    ifid_c    = 1'b1;
    idex_c    = 1'b1;
    exmem_c   = 1'b1;
    ifid_fl_c = 1'b0;
    idex_fl_c = 1'b0;
    bubble_c  = 1'b0;
    if (frozen) begin
      pc_c     = 1'b0;
      ifid_c   = 1'b0;
      idex_c   = 1'b0;
      exmem_c  = 1'b0;
      bubble_c = 1'b1;
    end else if (ex_branch_taken) begin
      // Branch wins over load-use: the dependent ID instruction is flushed anyway.
      ifid_fl_c = 1'b1;
      idex_fl_c = 1'b1;
    end else if (lu_hazard) begin
      pc_c      = 1'b0;
      ifid_c    = 1'b0;
      idex_fl_c = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign pc_en        = !reset && pc_c;
  assign ifid_en      = !reset && ifid_c;
  assign idex_en      = !reset && idex_c;
  assign exmem_en     = !reset && exmem_c;
  assign ifid_flush   = !reset && ifid_fl_c;
  assign idex_flush   = !reset && idex_fl_c;
  assign memwb_bubble = !reset && bubble_c;
  assign mem_timeout  = !reset && (state_q == ERR);

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  // Only a taken branch raises ifid_flush, so it doubles as the flush event.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (!pc_en && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
    if (ifid_flush && (flush_events_q != '1)) flush_events_d = flush_events_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule
